mem_rmw_lsu: RTL and testbench



---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_lane.sv | 76 +++++++
 rtl/mem_rmw_lsu.sv | 130 +++++++++++++
 tb/tb_mem_rmw_lsu.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
//============================================================================
// Module   : lsu_pkg
// Brief    : Shared encodings and types for the mem_rmw_lsu load/store unit.
//            Optional feature macro used by this unit: LSU_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

package lsu_pkg;

    // Access size encodings as presented on cpu_size (2'b11 behaves as a word)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Store sequencing states: IDLE serves every access, WRITE finishes an RMW
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } lsu_state_t;

    // Size codes 10 and 11 both select a full-word access
    function automatic logic is_word_size(input logic [1:0] size);
        return size[1];
    endfunction

endpackage : lsu_pkg

`default_nettype wire

// File: rtl/lsu_lane.sv
//============================================================================
// Module   : lsu_lane
// Brief    : Combinational byte-lane logic. Extracts and extends load data
//            from a memory word, and merges sub-word store data into the
//            word that is being read-modified-written.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] word,
    input  logic [31:0] data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte and halfword lanes of the memory word
    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'b00:   byte_sel = word[7:0];
            2'b01:   byte_sel = word[15:8];
            2'b10:   byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        // addr_lo[0] is intentionally ignored for halfwords
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    // Extend the selected lane to 32 bits for the register file
    always_comb begin
        load_data = word;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_data = word;
        endcase
    end

    // Replace the target lane(s) of the old word with the low store bits
    always_comb begin
        merged = data;
        case (size)
            SZ_BYTE: begin
                merged = word;
                case (addr_lo)
                    2'b00:   merged[7:0]   = data[7:0];
                    2'b01:   merged[15:8]  = data[7:0];
                    2'b10:   merged[23:16] = data[7:0];
                    default: merged[31:24] = data[7:0];
                endcase
            end
            SZ_HALF: begin
                merged = word;
                if (addr_lo[1]) begin
                    merged[31:16] = data[15:0];
                end else begin
                    merged[15:0] = data[15:0];
                end
            end
            default: merged = data;
        endcase
    end

endmodule : lsu_lane

`default_nettype wire

// File: rtl/mem_rmw_lsu.sv
//============================================================================
// Module   : mem_rmw_lsu
// Brief    : Load/store unit in front of a word-only, combinationally read
//            data memory. Loads and word stores complete in the issue cycle;
//            byte/halfword stores run as a two-cycle read-modify-write that
//            stalls the core for one cycle.
//            Optional macro LSU_ALIGN_CHECK_EN adds a misalign output and
//            suppresses misaligned accesses.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_rmw_lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        stall,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
`ifdef LSU_ALIGN_CHECK_EN
    output logic        misalign,
`endif
    input  logic [31:0] mem_rd
);

    lsu_state_t  state;
    lsu_state_t  state_next;
    logic [31:0] merged_q;
    logic [29:0] addr_q;
    logic        capture;
    logic        we_raw;
    logic        stall_raw;
    logic        word_access;
    logic        bad_align;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;

    assign word_access = is_word_size(cpu_size);

`ifdef LSU_ALIGN_CHECK_EN
    // Halfwords need addr[0]=0, words need addr[1:0]=0, only for real accesses
    assign bad_align = (cpu_we | cpu_re) &
                       (((cpu_size == SZ_HALF) & cpu_addr[0]) |
                        (word_access & (cpu_addr[1:0] != 2'b00)));
    assign misalign  = bad_align;
`else
    assign bad_align = 1'b0;
`endif

    lsu_lane u_lane (
        .size      (cpu_size),
        .addr_lo   (cpu_addr[1:0]),
        .sign_ext  (cpu_signed),
        .word      (mem_rd),
        .data      (cpu_wd),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    // Load data comes straight from memory; misaligned loads read as zero
    assign cpu_rd = bad_align ? 32'h0 : lane_load;

    // Next-state and memory-port steering for the RMW sequencer
    always_comb begin
        state_next = state;
        stall_raw  = 1'b0;
        we_raw     = 1'b0;
        capture    = 1'b0;
        mem_a      = {cpu_addr[31:2], 2'b00};
        mem_wd     = cpu_wd;
        case (state)
            IDLE: begin
                if (cpu_we && !bad_align) begin
                    if (word_access) begin
                        we_raw = 1'b1;
                    end else begin
                        // Memory is being read this cycle; keep the merge
                        stall_raw  = 1'b1;
                        capture    = 1'b1;
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_a      = {addr_q, 2'b00};
                mem_wd     = merged_q;
                we_raw     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset must never let a write or stall escape, even mid-RMW
    assign mem_we = we_raw & reset;
    assign stall  = stall_raw & reset;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Hold the merged word and its address for the WRITE cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            merged_q <= 32'h0;
            addr_q   <= 30'h0;
        end else if (capture) begin
            merged_q <= lane_merged;
            addr_q   <= cpu_addr[31:2];
        end
    end

endmodule : mem_rmw_lsu

`default_nettype wire

// File: tb/tb_mem_rmw_lsu.sv
//============================================================================
// Module   : tb_mem_rmw_lsu
// Brief    : Scoreboard bench for mem_rmw_lsu with a combinational-read
//            word memory model.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_rmw_lsu;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we, cpu_re, cpu_signed;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wd, cpu_rd, mem_a, mem_wd, mem_rd;
    logic        stall, mem_we;
`ifdef LSU_ALIGN_CHECK_EN
    logic        misalign;
`endif

    logic [31:0] mem [0:63];
    wr_t         wq[$];
    logic [31:0] rq[$];
    int          vectors    = 0;
    int          miscompares = 0;
    int          stall_cnt  = 0;

    always #5 clk = ~clk;

    mem_rmw_lsu dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .cpu_size   (cpu_size),
        .cpu_signed (cpu_signed),
        .cpu_addr   (cpu_addr),
        .cpu_wd     (cpu_wd),
        .cpu_rd     (cpu_rd),
        .stall      (stall),
        .mem_a      (mem_a),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
`ifdef LSU_ALIGN_CHECK_EN
        .misalign   (misalign),
`endif
        .mem_rd     (mem_rd)
    );

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every memory write and every load is checked against the queues
    always @(negedge clk) begin
        if (stall === 1'b1) stall_cnt++;
        if (mem_we === 1'b1) begin
            if (wq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got a=%h d=%h, expected no write", mem_a, mem_wd);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("write_addr", mem_a, e.a);
                chk("write_data", mem_wd, e.d);
            end
        end
        if (cpu_re === 1'b1) begin
            if (rq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_load: got %h, expected no load", cpu_rd);
            end else begin
                chk("load_data", cpu_rd, rq.pop_front());
            end
        end
    end

    task automatic drive(input logic we, input logic re, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        cpu_we = we; cpu_re = re; cpu_size = sz; cpu_signed = sg;
        cpu_addr = a; cpu_wd = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic word_store(input logic [31:0] a, input logic [31:0] d);
        wq.push_back('{a: a, d: d});
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, a, d);
        #3;
        chk("wstore_stall", {31'h0, stall}, 32'h0);
        chk("wstore_we", {31'h0, mem_we}, 32'h1);
    endtask

    task automatic load(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] exp);
        rq.push_back(exp);
        drive(1'b0, 1'b1, sz, sg, a, 32'h0);
    endtask

    // Core holds the store instruction through the stall, so inputs stay put
    task automatic sub_store(input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] merged);
        wq.push_back('{a: {a[31:2], 2'b00}, d: merged});
        drive(1'b1, 1'b0, sz, 1'b0, a, d);
        #3;
        chk("rmw_idle_stall", {31'h0, stall}, 32'h1);
        chk("rmw_idle_we", {31'h0, mem_we}, 32'h0);
        @(posedge clk);
        #4;
        chk("rmw_write_stall", {31'h0, stall}, 32'h0);
        chk("rmw_write_we", {31'h0, mem_we}, 32'h1);
    endtask

    initial begin
        reset = 1'b0;
        cpu_we = 1'b0; cpu_re = 1'b0; cpu_size = SZ_WORD; cpu_signed = 1'b0;
        cpu_addr = 32'h0; cpu_wd = 32'h0;

        // Reset state: requests are blocked while reset is low
        drive(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h4, 32'h5A);
        #3;
        chk("reset_stall", {31'h0, stall}, 32'h0);
        chk("reset_we_byte", {31'h0, mem_we}, 32'h0);
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h5A);
        #3;
        chk("reset_we_word", {31'h0, mem_we}, 32'h0);
        idle();
        reset = 1'b1;

        // Word store then word load
        word_store(32'h08, 32'hDEADBEEF);
        load(SZ_WORD, 1'b0, 32'h08, 32'hDEADBEEF);
        // Halfword store to upper lane, upper store-data bits ignored
        sub_store(SZ_HALF, 32'h0A, 32'h1234BEEF, 32'hBEEFBEEF);
        load(SZ_WORD, 1'b0, 32'h08, 32'hBEEFBEEF);
        // Store and load together: load sees the pre-write word
        wq.push_back('{a: 32'h08, d: 32'h12345678});
        rq.push_back(32'hBEEFBEEF);
        drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h08, 32'h12345678);
        load(SZ_WORD, 1'b0, 32'h08, 32'h12345678);

        // Byte store RMW
        word_store(32'h10, 32'h11223344);
        sub_store(SZ_BYTE, 32'h12, 32'h000000AB, 32'h11AB3344);
        load(SZ_WORD, 1'b0, 32'h10, 32'h11AB3344);

        // Sub-word loads, signed and unsigned
        word_store(32'h20, 32'h80017FFF);
        load(SZ_HALF, 1'b1, 32'h22, 32'hFFFF8001);
        load(SZ_HALF, 1'b0, 32'h22, 32'h00008001);
        load(SZ_HALF, 1'b1, 32'h20, 32'h00007FFF);
        load(SZ_BYTE, 1'b1, 32'h23, 32'hFFFFFF80);
        load(SZ_BYTE, 1'b0, 32'h21, 32'h0000007F);
        load(SZ_BYTE, 1'b1, 32'h20, 32'hFFFFFFFF);
        load(2'b11,   1'b1, 32'h20, 32'h80017FFF);
`ifdef LSU_ALIGN_CHECK_EN
        load(SZ_HALF, 1'b1, 32'h23, 32'h00000000);
`else
        load(SZ_HALF, 1'b1, 32'h23, 32'hFFFF8001);
`endif

        // Back-to-back byte stores: 8 cycles, 4 stall pulses
        word_store(32'h30, 32'hAAAAAAAA);
        stall_cnt = 0;
        sub_store(SZ_BYTE, 32'h30, 32'h01, 32'hAAAAAA01);
        sub_store(SZ_BYTE, 32'h31, 32'h02, 32'hAAAA0201);
        sub_store(SZ_BYTE, 32'h32, 32'h03, 32'hAA030201);
        sub_store(SZ_BYTE, 32'h33, 32'h04, 32'h04030201);
        load(SZ_WORD, 1'b0, 32'h30, 32'h04030201);
        chk("b2b_stall_pulses", stall_cnt, 32'd4);

        // Reset asserted in the WRITE cycle aborts the store
        word_store(32'h40, 32'hCAFEF00D);
        drive(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h40, 32'h55);
        #3;
        chk("abort_idle_stall", {31'h0, stall}, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        chk("abort_we", {31'h0, mem_we}, 32'h0);
        chk("abort_stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1;
        chk("abort_mem", mem[16], 32'hCAFEF00D);
        cpu_we = 1'b0;
        reset = 1'b1;
        // A fresh byte store stalling proves the FSM sits in IDLE
        sub_store(SZ_BYTE, 32'h41, 32'h66, 32'hCAFE660D);
        load(SZ_WORD, 1'b0, 32'h40, 32'hCAFE660D);

`ifdef LSU_ALIGN_CHECK_EN
        // Misaligned word and halfword stores are suppressed
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h05, 32'h99999999);
        #3;
        chk("mis_word_flag", {31'h0, misalign}, 32'h1);
        chk("mis_word_we", {31'h0, mem_we}, 32'h0);
        chk("mis_word_stall", {31'h0, stall}, 32'h0);
        drive(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h09, 32'h9999);
        #3;
        chk("mis_half_flag", {31'h0, misalign}, 32'h1);
        chk("mis_half_stall", {31'h0, stall}, 32'h0);
        idle();
        #3;
        chk("mis_idle_flag", {31'h0, misalign}, 32'h0);
        chk("mis_mem", mem[2], 32'h12345678);
`endif

        idle();
        idle();
        chk("write_queue_drained", wq.size(), 32'd0);
        chk("load_queue_drained", rq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mem_rmw_lsu

`default_nettype wire
